mem_io_bus_ctrl: RTL and testbench
==================================

Name: mem_io_bus_ctrl

Overview:
- Bus controller between the CPU load/store/fetch port and the unified 8K x 32 instruction/data RAM.
- Decodes each CPU byte address to RAM or to a small polled-IO register bank (switches, button event flags, LEDs).
- Sequences the RAM's 1-cycle synchronous read and its write-blocks-read behaviour.
- Returns every access to the CPU with a single-cycle ready pulse.

Parameters:
- MEM_AW, 13, RAM word-address width (8192 words).
- IO_BASE, 16'hFFFF, value of cpu_addr[31:16] that selects the IO region.
- SW_W, 16, switch input width.
- BTN_W, 4, button input width.
- LED_W, 16, LED register width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  access request; held by the CPU until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load/fetch.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid while cpu_ready = 1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_we  out  1  RAM write enable.
- mem_addr  out  MEM_AW  RAM word address.
- mem_din  out  32  RAM write data.
- mem_dout  in  32  RAM read data (registered inside the RAM).
- sw_in  in  SW_W  raw switch levels (asynchronous).
- btn_in  in  BTN_W  raw button levels (asynchronous).
- led_out  out  LED_W  LED register.

Behaviour:
- Reset (asynchronous, rst_n = 0): state IDLE; cpu_ready, cpu_rdata, mem_we, mem_addr, mem_din, led_out, button flags and synchronizers all go to 0. All outputs are registered.
- Address decode on cpu_addr:
  - RAM: cpu_addr[31:15] == 0; word address = cpu_addr[14:2].
  - IO: cpu_addr[31:16] == IO_BASE, with offsets 0x0 SW (read-only), 0x4 BTN flags (read clears), 0x8 LED (read/write).
  - Anything else is unmapped: reads return 0, writes are ignored, cpu_ready still pulses.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, RESP.
  - IDLE: cpu_req is sampled only here, and the request is latched at that edge.
  - RAM read: IDLE -> RD_ADDR, driving mem_addr with mem_we = 0. RD_ADDR -> RD_DATA while the RAM registers the word. In RD_DATA, mem_dout is captured into cpu_rdata and the FSM moves to RESP. cpu_ready is high 3 cycles after the accept edge.
  - RAM write: IDLE -> WR with mem_we = 1, mem_addr and mem_din loaded. In WR, mem_we drops and the FSM moves to RESP. cpu_ready is high 2 cycles after the accept edge.
  - IO or unmapped access: IDLE -> RESP directly, loading cpu_rdata or updating led_out. cpu_ready is high 1 cycle after the accept edge.
  - RESP: cpu_ready = 1 for exactly one cycle, then IDLE. cpu_req is ignored in RESP. If cpu_req is still high back in IDLE, a new access starts.
- mem_we is asserted only in the single WR cycle. It is never asserted during a read, because the RAM does not read while written.
- SW read: returns a 2-flop-synchronized sw_in, zero-extended to 32 bits.
- BTN flags:
  - btn_in passes through a 2-flop synchronizer. A rising edge sets the sticky flag for that bit.
  - A BTN read returns the flags in bits [BTN_W-1:0] and clears them at the accept edge.
  - If an edge and a clear land on the same cycle, the set wins and the flag stays 1.
  - Held buttons do not re-set the flag.
- LED:
  - Write: led_out <= cpu_wdata[LED_W-1:0].
  - Read: returns led_out, zero-extended.
  - Writes to SW or BTN are ignored.
- cpu_rdata holds its last value outside RESP. After a store, its value is don't-care.
- Reset mid-operation: any state returns to IDLE with no ready pulse and mem_we dropped immediately. A RAM write caught mid-WR may or may not land; software must not rely on it.

Test Plan:
- Post-reset: rst_n low for 3 cycles, then release -> all outputs 0, and the first cpu_req is accepted in the next IDLE cycle.
- RAM write then read:
  - Store 0xDEADBEEF to 0x00000010 -> mem_we high for exactly 1 cycle with mem_addr = 4; ready 2 cycles after accept.
  - Load 0x00000010 -> cpu_rdata = 0xDEADBEEF with ready 3 cycles after accept, and mem_we stays 0 throughout.
- LED and unmapped accesses:
  - Store 0x0001A5A5 to 0xFFFF0008 -> led_out = 0xA5A5, ready 1 cycle after accept.
  - Load 0xFFFF0008 -> 0x0000A5A5.
  - Store to 0x80000000 -> no RAM or IO change, ready still pulses; a load from there returns 0.
- Button polling:
  - Pulse btn_in[2] high for 5 cycles -> read 0xFFFF0004 returns 0x4; an immediate second read returns 0x0.
  - Rising edge timed to the clearing cycle -> the second read returns 0x4.
- Back-to-back requests with cpu_req held high across ready -> each access completes with exactly one ready pulse and no request is lost or duplicated.
- Reset during RD_DATA -> no cpu_ready; state returns to IDLE; the next load completes normally.

Source files
------------

// File: rtl/mem_io_bus_ctrl_if.sv
// CPU load/store/fetch port between the core (master) and mem_io_bus_ctrl (slave).
interface mem_io_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;

  modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  input  cpu_rdata, cpu_ready);
  modport slave  (input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
                  output cpu_rdata, cpu_ready);
endinterface

// File: rtl/mem_io_bus_ctrl.sv
// Bus controller: decodes CPU accesses to the unified RAM or a polled IO bank
// (switches, button event flags, LEDs) and returns each with a one-cycle ready.
module mem_io_bus_ctrl #(
  parameter int unsigned MEM_AW  = 13,
  parameter logic [15:0] IO_BASE = 16'hFFFF,
  parameter int unsigned SW_W    = 16,
  parameter int unsigned BTN_W   = 4,
  parameter int unsigned LED_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_io_bus_ctrl_if.slave    bus,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_din,
  input  logic [31:0]         mem_dout,
  input  logic [SW_W-1:0]     sw_in,
  input  logic [BTN_W-1:0]    btn_in,
  output logic [LED_W-1:0]    led_out
);

  localparam int unsigned RAM_TOP = MEM_AW + 2;
  localparam logic [13:0] OFF_SW  = 14'd0;
  localparam logic [13:0] OFF_BTN = 14'd1;
  localparam logic [13:0] OFF_LED = 14'd2;

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RESP} state_t;
  state_t state;

  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [BTN_W-1:0] btn_s1, btn_s2, btn_s3, btn_flags;
  logic [BTN_W-1:0] btn_clr_c;
  logic             sel_ram_c, sel_io_c, accept_c;
  logic [13:0]      io_off_c;
  logic [31:0]      io_rdata_c;
  logic             unused_addr_bits;

  // Byte-lane bits are irrelevant to a word-wide bus.
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  assign sel_ram_c = (bus.cpu_addr[31:RAM_TOP] == '0);
  assign sel_io_c  = (bus.cpu_addr[31:16] == IO_BASE);
  assign io_off_c  = bus.cpu_addr[15:2];
  assign accept_c  = (state == IDLE) && bus.cpu_req;
  assign btn_clr_c = {BTN_W{accept_c && !bus.cpu_we && sel_io_c && (io_off_c == OFF_BTN)}};

  // IO read mux; holes in the IO page read as zero.
  always_comb begin
    io_rdata_c = '0;
    if (sel_io_c) begin
      case (io_off_c)
        OFF_SW:  io_rdata_c = 32'(sw_s2);
        OFF_BTN: io_rdata_c = 32'(btn_flags);
        OFF_LED: io_rdata_c = 32'(led_out);
        default: io_rdata_c = '0;
      endcase
    end
  end

  // Input synchronizers and sticky button flags; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1     <= '0;
      sw_s2     <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_s3    <= '0;
      btn_flags <= '0;
    end else begin
      sw_s1     <= sw_in;
      sw_s2     <= sw_s1;
      btn_s1    <= btn_in;
      btn_s2    <= btn_s1;
      btn_s3    <= btn_s2;
      btn_flags <= (btn_flags & ~btn_clr_c) | (btn_s2 & ~btn_s3);
    end
  end

  // Access sequencer; cpu_ready is high exactly while in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bus.cpu_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      led_out       <= '0;
    end else begin
      bus.cpu_ready <= 1'b0;
      mem_we        <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (sel_ram_c) begin
              mem_addr <= bus.cpu_addr[RAM_TOP-1:2];
              if (bus.cpu_we) begin
                mem_we  <= 1'b1;
                mem_din <= bus.cpu_wdata;
                state   <= WR;
              end else begin
                state <= RD_ADDR;
              end
            end else begin
              state         <= RESP;
              bus.cpu_ready <= 1'b1;
              if (bus.cpu_we) begin
                if (sel_io_c && (io_off_c == OFF_LED)) led_out <= bus.cpu_wdata[LED_W-1:0];
              end else begin
                bus.cpu_rdata <= io_rdata_c;
              end
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          bus.cpu_rdata <= mem_dout;
          bus.cpu_ready <= 1'b1;
          state         <= RESP;
        end
        WR: begin
          bus.cpu_ready <= 1'b1;
          state         <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_bus_ctrl.sv
// Self-checking bench for mem_io_bus_ctrl: directed steps plus random accesses
// checked against a memory-map reference model and a behavioural RAM.
module tb_mem_io_bus_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic [15:0] sw_in;
  logic [3:0]  btn_in;
  logic [15:0] led_out;

  mem_io_bus_ctrl_if bus();

  mem_io_bus_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .sw_in    (sw_in),
    .btn_in   (btn_in),
    .led_out  (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency, no read on a write cycle.
  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    else        mem_dout      <= ram[mem_addr];
  end

  // Reference model state: what software should observe in the memory map.
  logic [31:0] ref_mem [0:8191];
  logic [15:0] ref_led;
  logic [3:0]  ref_flags;
  logic [31:0] ref_sw;
  bit          kept;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CPU access; keep=1 leaves cpu_req high across ready for a back-to-back follow-up.
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit keep, input string tag);
    bit          is_ram, is_io, got;
    int          exp_lat, lat, we_cnt;
    int unsigned word, off;
    logic [31:0] exp_rd, rd;
    is_ram  = (addr < 32'h0000_8000);
    is_io   = (addr / 32'h1_0000) == 32'h0000_FFFF;
    word    = addr / 4;
    off     = (addr % 32'h1_0000) & ~32'd3;
    exp_rd  = 32'h0;
    exp_lat = is_ram ? (we ? 2 : 3) : 1;
    if (kept) exp_lat = exp_lat + 1;
    if (is_ram) exp_rd = ref_mem[word];
    else if (is_io && off == 0) exp_rd = ref_sw;
    else if (is_io && off == 4) exp_rd = {28'h0, ref_flags};
    else if (is_io && off == 8) exp_rd = {16'h0, ref_led};

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    got = 1'b0; lat = 0; we_cnt = 0; rd = 32'h0;
    for (int k = 1; k <= 12 && !got; k++) begin
      @(posedge clk);
      #1;
      if (mem_we) begin
        we_cnt++;
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'(word));
        chk({tag, " mem_din"}, mem_din, wdata);
      end
      if (bus.cpu_ready) begin
        got = 1'b1;
        lat = k;
        rd  = bus.cpu_rdata;
      end
    end
    chk({tag, " ready seen"}, 32'(got), 32'd1);

    if (we) begin
      if (is_ram) ref_mem[word] = wdata;
      else if (is_io && off == 8) ref_led = wdata[15:0];
    end else if (is_io && off == 4) begin
      ref_flags = 4'h0;
    end

    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " mem_we cycles"}, 32'(we_cnt), (we && is_ram) ? 32'd1 : 32'd0);
    if (!we) chk({tag, " rdata"}, rd, exp_rd);
    chk({tag, " led_out"}, 32'(led_out), 32'(ref_led));

    if (keep) begin
      kept = 1'b1;
    end else begin
      bus.cpu_req = 1'b0;
      kept = 1'b0;
      idle_cycles(1);
      chk({tag, " ready single pulse"}, 32'(bus.cpu_ready), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish after 1 ms, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = 32'h0;
      ref_mem[i] = 32'h0;
    end
    ref_led = 16'h0; ref_flags = 4'h0; kept = 1'b0;
    ref_sw = 32'h0000_3C5A;
    sw_in = 16'h3C5A; btn_in = 4'h0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;

    // Reset for 3 cycles
    rst_n = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    chk("reset cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("reset cpu_rdata", bus.cpu_rdata, 32'h0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset mem_din", mem_din, 32'h0);
    chk("reset led_out", 32'(led_out), 32'd0);

    // RAM write then read
    access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, "ram store");
    chk("ram array word 4", ram[4], 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram load");
    access(1'b1, 32'h0000_7FFC, 32'h1234_5678, 1'b0, "ram store top");
    access(1'b0, 32'h0000_7FFC, 32'h0, 1'b0, "ram load top");

    // LED, SW and unmapped accesses
    access(1'b1, 32'hFFFF_0008, 32'h0001_A5A5, 1'b0, "led store");
    access(1'b0, 32'hFFFF_000A, 32'h0, 1'b0, "led load");
    access(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "unmapped store");
    access(1'b0, 32'h8000_0000, 32'h0, 1'b0, "unmapped load");
    access(1'b0, 32'h0000_8000, 32'h0, 1'b0, "above ram load");
    access(1'b1, 32'hFFFF_0000, 32'h0000_1111, 1'b0, "sw store ignored");
    access(1'b0, 32'hFFFF_0000, 32'h0, 1'b0, "sw load");
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, "ram unchanged");

    // Button pulse sets a sticky flag, read clears it
    btn_in = 4'b0100;
    idle_cycles(5);
    btn_in = 4'b0000;
    idle_cycles(4);
    ref_flags = 4'b0100;
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn read 1");
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn read 2");

    // Edge landing on the clearing edge survives the clear
    btn_in = 4'b0010;
    idle_cycles(5);
    ref_flags = 4'b0010;
    btn_in = 4'b0110;
    idle_cycles(2);
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn clear race");
    ref_flags = 4'b0100;
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn set wins");
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn held no reset");
    btn_in = 4'b0000;
    idle_cycles(4);
    access(1'b0, 32'hFFFF_0004, 32'h0, 1'b0, "btn release");

    // Back-to-back with cpu_req held across ready
    access(1'b1, 32'h0000_0014, 32'hCAFE_0001, 1'b1, "b2b store");
    access(1'b0, 32'h0000_0014, 32'h0, 1'b1, "b2b load");
    access(1'b1, 32'hFFFF_0008, 32'h0000_0F0F, 1'b1, "b2b led store");
    access(1'b0, 32'hFFFF_0008, 32'h0, 1'b1, "b2b led load");
    access(1'b1, 32'h0000_0018, 32'hCAFE_0002, 1'b1, "b2b store 2");
    access(1'b0, 32'h0000_0018, 32'h0, 1'b0, "b2b load 2");

    // Reset while the load is in RD_DATA
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0010;
    idle_cycles(2);
    rst_n = 1'b0;
    #1;
    chk("midreset cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("midreset mem_we", 32'(mem_we), 32'd0);
    chk("midreset cpu_rdata", bus.cpu_rdata, 32'h0);
    bus.cpu_req = 1'b0;
    idle_cycles(2);
    rst_n = 1'b1;
    ref_led = 16'h0; ref_flags = 4'h0;
    for (int i = 0; i < 3; i++) begin
      idle_cycles(1);
      chk("post midreset no ready", 32'(bus.cpu_ready), 32'd0);
    end
    access(1'b0, 32'h0000_0010, 32'h0, 1'b0, "load after midreset");

    // Random traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      int unsigned sel;
      logic [31:0] a;
      bit          w, k;
      sel = $urandom_range(0, 9);
      w   = 1'($urandom_range(0, 1));
      k   = (n == 149) ? 1'b0 : 1'($urandom_range(0, 1));
      if (sel < 5) begin
        a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      end else if (sel < 8) begin
        a = 32'hFFFF_0000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = 32'h0000_8000;
          1:       a = 32'h8000_0000;
          2:       a = 32'hFFFE_0008;
          default: a = 32'h0001_0010;
        endcase
      end
      access(w, a, $urandom, k, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
